// File: rtl/quad_gpio_blink.sv
// LED conditioning stage behind quad_gpio: per-channel pass / blink / pulse / inverted mux
// with a shared prescaled tick and a Wishbone config port. Pulse mode exists only with QUAD_BLINK_PULSE_EN.

module quad_gpio_blink_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [1:0] mode_nx,
  input  logic       gpio,
  input  logic       rise,
  input  logic       tick,
  input  logic       phase,
  input  logic [7:0] pulse_len,
  output logic       led,
  output logic       active
);
`ifdef QUAD_BLINK_PULSE_EN
  logic [7:0] cnt;

  // Keyed on the post-write mode so leaving pulse mode clears the count on the ack edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   cnt <= '0;
    else if (mode_nx != 2'b10)    cnt <= '0;
    else if (rise)                cnt <= pulse_len;
    else if (tick && cnt != '0)   cnt <= cnt - 8'd1;

  assign active = (cnt != '0);
`else
  logic unused_lane;
  assign unused_lane = ^{clk, rst_n, mode_nx, rise, tick, pulse_len};
  assign active      = 1'b0;
`endif

  always_comb begin
    led = gpio;
    case (mode)
      2'b01:   led = gpio & phase;
`ifdef QUAD_BLINK_PULSE_EN
      2'b10:   led = active;
`endif
      2'b11:   led = ~gpio;
      default: led = gpio;
    endcase
  end
endmodule

module quad_gpio_blink #(
  parameter int                    CHANNELS     = 8,
  parameter int                    PRESCALE_W   = 24,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 24'd999
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_wb_addr,
  input  logic [31:0]         i_wb_dat,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  output logic [31:0]         o_wb_dat,
  output logic                o_wb_ack,
  input  logic [CHANNELS-1:0] i_gpio,
  output logic [CHANNELS-1:0] o_led
);
  logic [CHANNELS-1:0][1:0] mode_q, mode_nx;
  logic [PRESCALE_W-1:0]    prescale_q, pre_cnt;
  logic [7:0]               blink_half_q, blink_cnt, pulse_len_q;
  logic [CHANNELS-1:0]      gpio_q, gpio_prev, rise, active;
  logic                     phase, tick, wb_acc, wr;
  logic [1:0]               sel;
  logic [31:0]              rdata;
  logic                     unused_top;

  assign unused_top = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_dat[31:PRESCALE_W]};

  // A new access is taken only while ack is low, giving one access per two clocks.
  assign wb_acc  = i_wb_cyc & ~o_wb_ack;
  assign wr      = wb_acc & i_wb_we;
  assign sel     = i_wb_addr[3:2];
  assign mode_nx = (wr && sel == 2'd0) ? i_wb_dat[2*CHANNELS-1:0] : mode_q;
  assign tick    = (pre_cnt == '0) && !(wr && sel == 2'd1);
  assign rise    = gpio_q & ~gpio_prev;

  always_comb begin
    rdata = '0;
    case (sel)
      2'd0:    rdata[2*CHANNELS-1:0] = mode_q;
      2'd1:    rdata[PRESCALE_W-1:0] = prescale_q;
      2'd2:    rdata[15:0]           = {pulse_len_q, blink_half_q};
      default: rdata[2*CHANNELS-1:0] = {o_led, active};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_wb_ack     <= 1'b0;
      o_wb_dat     <= '0;
      mode_q       <= '0;
      prescale_q   <= PRESCALE_RST;
      blink_half_q <= '0;
    end else begin
      o_wb_ack <= wb_acc;
      o_wb_dat <= wb_acc ? rdata : '0;
      mode_q   <= mode_nx;
      if (wr && sel == 2'd1) prescale_q   <= i_wb_dat[PRESCALE_W-1:0];
      if (wr && sel == 2'd2) blink_half_q <= i_wb_dat[7:0];
    end

`ifdef QUAD_BLINK_PULSE_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)              pulse_len_q <= '0;
    else if (wr && sel == 2'd2) pulse_len_q <= i_wb_dat[15:8];
`else
  assign pulse_len_q = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      gpio_q    <= '0;
      gpio_prev <= '0;
    end else begin
      gpio_q    <= i_gpio;
      gpio_prev <= gpio_q;
    end

  // Prescaler: a PRESCALE write restarts the count and suppresses that edge's tick.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)                pre_cnt <= '0;
    else if (wr && sel == 2'd1)  pre_cnt <= i_wb_dat[PRESCALE_W-1:0];
    else if (pre_cnt == '0)      pre_cnt <= prescale_q;
    else                         pre_cnt <= pre_cnt - PRESCALE_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == '0) begin
        blink_cnt <= blink_half_q;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt - 8'd1;
      end
    end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    quad_gpio_blink_lane u_lane (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .mode      (mode_q[i]),
      .mode_nx   (mode_nx[i]),
      .gpio      (gpio_q[i]),
      .rise      (rise[i]),
      .tick      (tick),
      .phase     (phase),
      .pulse_len (pulse_len_q),
      .led       (o_led[i]),
      .active    (active[i])
    );
  end
endmodule

// File: tb/tb_quad_gpio_blink.sv
// Directed bench for quad_gpio_blink: expectations queued at stimulus time, popped at each check.
`timescale 1ns/1ps
module tb_quad_gpio_blink;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic [31:0] i_wb_addr = '0, i_wb_dat = '0;
  logic        i_wb_we = 1'b0, i_wb_cyc = 1'b0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic [7:0]  i_gpio = '0, o_led;

  int          errors = 0, checks = 0;
  logic [31:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  quad_gpio_blink dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_addr(i_wb_addr), .i_wb_dat(i_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .i_gpio(i_gpio), .o_led(o_led)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: got %h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic wb_access(input logic [31:0] addr, input logic we, input logic [31:0] wdat,
                           input string tag);
    bit got = 0;
    i_wb_addr = addr; i_wb_we = we; i_wb_dat = wdat; i_wb_cyc = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      step(1);
      got = o_wb_ack;
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL %s: got no ack expected ack within 8 clocks", tag);
      if (!we && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (!we) check({tag, "_rd"}, o_wb_dat);
      step(1);  // cyc still held: ack must drop anyway
      expect_val(32'd0); check({tag, "_ack1clk"}, {31'd0, o_wb_ack});
      expect_val(32'd0); check({tag, "_dat_idle"}, o_wb_dat);
    end
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] d, input string tag);
    wb_access(addr, 1'b1, d, tag);
  endtask

  task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    expect_val(exp);
    wb_access(addr, 1'b0, 32'd0, tag);
  endtask

  task automatic wait_led(input int b, input logic lvl, input string tag);
    for (int k = 0; k < 40 && o_led[b] !== lvl; k++) step(1);
    expect_val({31'd0, lvl});
    check(tag, {31'd0, o_led[b]});
  endtask

  task automatic run_len(input int b, input logic lvl, output int n);
    n = 0;
    while (o_led[b] === lvl && n < 40) begin
      n++;
      step(1);
    end
  endtask

  task automatic count_high(input int b, input int clocks, output int h);
    h = 0;
    for (int k = 0; k < clocks; k++) begin
      if (o_led[b] === 1'b1) h++;
      step(1);
    end
  endtask

  initial begin
    int n;
    step(3);
    expect_val(32'd0); check("rst_led", {24'd0, o_led});
    expect_val(32'd0); check("rst_ack", {31'd0, o_wb_ack});
    expect_val(32'd0); check("rst_dat", o_wb_dat);
    i_rst_n = 1'b1;
    step(1);
    wb_read(32'h0, 32'h0,      "rst_mode");
    wb_read(32'h4, 32'd999,    "rst_prescale");
    wb_read(32'h8, 32'h0,      "rst_cfg");
    wb_read(32'hC, 32'h0,      "rst_status");

    // pass
    wb_write(32'h0, 32'h0, "w_mode_pass");
    i_gpio = 8'hAA; step(1);
    expect_val(32'hAA); check("pass_led", {24'd0, o_led});
    wb_read(32'hC, 32'h0000AA00, "pass_status");

    // inverted on ch0
    wb_write(32'h0, 32'h3, "w_mode_inv");
    i_gpio = 8'h00; step(1);
    expect_val(32'h01); check("inv_led0", {24'd0, o_led});
    i_gpio = 8'h0F; step(1);
    expect_val(32'h0E); check("inv_led1", {24'd0, o_led});

    // blink on ch1: tick every 4 clocks, phase flips every 2 ticks
    i_gpio = 8'h00;
    wb_write(32'h4, 32'd3, "w_pre3");
    wb_write(32'h8, 32'd1, "w_half1");
    wb_write(32'h0, 32'h4, "w_mode_blink");
    i_gpio = 8'h02;
    wait_led(1, 1'b0, "blink_find_lo");
    wait_led(1, 1'b1, "blink_find_hi");
    run_len(1, 1'b1, n); expect_val(32'd8); check("blink_high_len", n);
    run_len(1, 1'b0, n); expect_val(32'd8); check("blink_low_len", n);
    run_len(1, 1'b1, n); expect_val(32'd8); check("blink_high_len2", n);
    i_gpio = 8'h00; step(1);
    count_high(1, 20, n); expect_val(32'd0); check("blink_gated", n);

    // pulse on ch2
    wb_write(32'h4, 32'd0, "w_pre0");
    wb_write(32'h0, 32'h20, "w_mode_pulse");
    wb_write(32'h8, 32'h0300, "w_plen3");
    step(2);
`ifdef QUAD_BLINK_PULSE_EN
    i_gpio = 8'h04; step(1);
    expect_val(32'h0); check("pulse_lat1", {24'd0, o_led});
    step(1);
    expect_val(32'h04); check("pulse_lat2", {24'd0, o_led});
    run_len(2, 1'b1, n); expect_val(32'd3); check("pulse_width", n);
    i_gpio = 8'h00; step(2);
    i_gpio = 8'h04; step(2);
    wb_read(32'hC, 32'h00000404, "pulse_status");
    i_gpio = 8'h00; step(4);
    i_gpio = 8'h04; step(1);
    i_gpio = 8'h00; step(1);
    i_gpio = 8'h04;
    run_len(2, 1'b1, n); expect_val(32'd5); check("pulse_retrig", n);
    i_gpio = 8'h00; step(2);
    wb_write(32'h8, 32'h0, "w_plen0");
    i_gpio = 8'h04; step(1);
    count_high(2, 8, n); expect_val(32'd0); check("pulse_len0", n);
`else
    i_gpio = 8'h04; step(1);
    expect_val(32'h04); check("mode10_pass", {24'd0, o_led});
    wb_read(32'h8, 32'h0, "plen_not_stored");
    wb_read(32'hC, 32'h00000400, "status_nopulse");
`endif

    // reset mid-pulse and mid-transaction
    i_gpio = 8'h00;
    wb_write(32'h8, 32'h0000C800, "w_plen200");
    step(2);
    i_gpio = 8'h04; step(3);
    expect_val(32'h04); check("pre_rst_led", {24'd0, o_led});
    i_wb_addr = 32'h0; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
    #3 i_rst_n = 1'b0;
    #1;
    expect_val(32'h0); check("rst_async_led", {24'd0, o_led});
    step(2);
    expect_val(32'h0); check("rst_no_ack", {31'd0, o_wb_ack});
    i_wb_cyc = 1'b0; step(1);
    i_rst_n = 1'b1; step(1);
    wb_read(32'h0, 32'h0,   "post_rst_mode");
    wb_read(32'h4, 32'd999, "post_rst_prescale");

    // bus masking and STATUS read-only
    wb_write(32'h0, 32'hFFFFFFFF, "w_all_mode");
    wb_read (32'h0, 32'h0000FFFF, "mask_mode");
    wb_write(32'h4, 32'hFFFFFFFF, "w_all_pre");
    wb_read (32'h4, 32'h00FFFFFF, "mask_pre");
    wb_write(32'h8, 32'hFFFFFFFF, "w_all_cfg");
`ifdef QUAD_BLINK_PULSE_EN
    wb_read (32'h8, 32'h0000FFFF, "mask_cfg");
`else
    wb_read (32'h8, 32'h000000FF, "mask_cfg");
`endif
    wb_read (32'hC, 32'h0000FB00, "status_before");
    wb_write(32'hC, 32'hFFFFFFFF, "w_status");
    wb_read (32'hC, 32'h0000FB00, "status_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
